div_ctrl: RTL and testbench



---
 rtl/div_pkg.sv | 13 +
 rtl/div_ctrl.sv | 114 +++++++++++
 tb/tb_div_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the 8-bit non-restoring divider sequencer.
package div_pkg;
   // FSM state encoding (3-bit, kept as plain constants for legacy tools)
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOAD    = 3'd1;
   localparam logic [2:0] SHIFT   = 3'd2;
   localparam logic [2:0] ADDSUB  = 3'd3;
   localparam logic [2:0] CORRECT = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam int DIV_WIDTH = 8;
   localparam int DIV_ITER  = 8;
endpackage

// File: rtl/div_ctrl.sv
// Sequencing FSM for the non-restoring divider datapath: latches operands,
// walks load -> 8x(shift, add/sub) -> correction, then registers the result.
// A zero divisor bypasses the datapath and answers on the very next edge.
module div_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH  = DIV_WIDTH,
   parameter int ITER_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend_in,
   input  logic [WIDTH-1:0]   divisor_in,
   input  logic               rem_sign,
   input  logic [2*WIDTH-1:0] dp_reg_data,
   output logic [WIDTH-1:0]   dividend_q,
   output logic [WIDTH-1:0]   divisor_q,
   output logic               load,
   output logic               shift_en,
   output logic               add_en,
   output logic               sub_en,
   output logic               final_add,
   output logic               count_en,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero
);

   logic [2:0]        state;
   logic [ITER_W-1:0] iter;

   assign busy = (state != IDLE);

   // State sequencing, iteration counter and operand latches
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         iter       <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (divisor_in != '0)) begin
                  dividend_q <= dividend_in;
                  divisor_q  <= divisor_in;
                  iter       <= '0;
                  state      <= LOAD;
               end
            end
            LOAD:    state <= SHIFT;
            SHIFT:   state <= ADDSUB;
            ADDSUB: begin
               iter  <= iter + 1'b1;
               // last iteration is when the counter is about to wrap
               state <= (iter == '1) ? CORRECT : SHIFT;
            end
            CORRECT: state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Result registers and the one-cycle done pulse (normal and zero-divisor)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start && (divisor_in == '0)) begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend_in;
         end else if (state == DONE) begin
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            quotient    <= dp_reg_data[WIDTH-1:0];
            remainder   <= dp_reg_data[2*WIDTH-1:WIDTH];
         end
      end
   end

   // Datapath strobes decoded from state; add/sub picked by post-shift sign
   always_comb begin
      load      = 1'b0;
      shift_en  = 1'b0;
      add_en    = 1'b0;
      sub_en    = 1'b0;
      final_add = 1'b0;
      count_en  = 1'b0;
      case (state)
         LOAD:    load = 1'b1;
         SHIFT: begin
            shift_en = 1'b1;
            count_en = 1'b1;
         end
         ADDSUB: begin
            add_en = rem_sign;
            sub_en = ~rem_sign;
         end
         CORRECT: final_add = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: a behavioural non-restoring datapath answers the
// strobes; directed operations push hand-computed results into a queue and
// a negedge monitor pops and checks on every done pulse.
module tb_div_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend_in = '0, divisor_in = '0;
   logic       rem_sign;
   logic [15:0] dp_reg_data;
   logic [7:0] dividend_q, divisor_q, quotient, remainder;
   logic       load, shift_en, add_en, sub_en, final_add, count_en;
   logic       busy, done, div_by_zero;

   div_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .dividend_in(dividend_in), .divisor_in(divisor_in),
      .rem_sign(rem_sign), .dp_reg_data(dp_reg_data),
      .dividend_q(dividend_q), .divisor_q(divisor_q),
      .load(load), .shift_en(shift_en), .add_en(add_en), .sub_en(sub_en),
      .final_add(final_add), .count_en(count_en),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: signed partial remainder R, quotient shift reg Q
   int         dp_r;
   logic [7:0] dp_q;
   assign rem_sign    = (dp_r < 0);
   assign dp_reg_data = {dp_r[7:0], dp_q};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_r <= 0;
         dp_q <= '0;
      end else if (load) begin
         dp_r <= 0;
         dp_q <= dividend_q;
      end else if (shift_en) begin
         dp_r <= 2 * dp_r + int'(dp_q[7]);
         dp_q <= {dp_q[6:0], 1'b0};
      end else if (sub_en) begin
         dp_r <= dp_r - int'(divisor_q);
         dp_q <= {dp_q[7:1], (dp_r - int'(divisor_q)) >= 0};
      end else if (add_en) begin
         dp_r <= dp_r + int'(divisor_q);
         dp_q <= {dp_q[7:1], (dp_r + int'(divisor_q)) >= 0};
      end else if (final_add && dp_r < 0) begin
         dp_r <= dp_r + int'(divisor_q);
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         cyc;
      logic [39:0] trace;   // {load, shift, count_en, add+sub, final_add} counts
      int         nbusy;
   } exp_t;
   exp_t sb[$];

   int n_pass = 0, n_total = 0, n_ops = 0, ovl = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Monitor: per-operation strobe statistics and scoreboard check on done
   int nld = 0, nsh = 0, ncnt = 0, nas = 0, nfa = 0, nbz = 0;
   always @(negedge clk) begin
      if (reset) begin
         nld = 0; nsh = 0; ncnt = 0; nas = 0; nfa = 0; nbz = 0;
      end else begin
         if ($countones({load, shift_en, add_en, sub_en, final_add}) > 1) ovl++;
         nld += int'(load);  nsh += int'(shift_en); ncnt += int'(count_en);
         nas += int'(add_en) + int'(sub_en); nfa += int'(final_add);
         nbz += int'(busy);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               n_ops++;
               chk($sformatf("op%0d_quotient", n_ops), quotient, e.q);
               chk($sformatf("op%0d_remainder", n_ops), remainder, e.r);
               chk($sformatf("op%0d_div_by_zero", n_ops), div_by_zero, e.dz);
               chk($sformatf("op%0d_done_cycle", n_ops), cyc, e.cyc);
               chk($sformatf("op%0d_strobe_trace_busy", n_ops),
                   {nld[7:0], nsh[7:0], ncnt[7:0], nas[7:0], nfa[7:0], nbz[7:0]},
                   {e.trace, e.nbusy[7:0]});
            end
            nld = 0; nsh = 0; ncnt = 0; nas = 0; nfa = 0; nbz = 0;
         end
      end
   end

   function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                               input logic [7:0] dvs, input int c);
      exp_t e;
      e.q = q; e.r = r; e.dz = (dvs == 0); e.cyc = c;
      if (dvs == 0) begin
         e.trace = '0; e.nbusy = 0;
      end else begin
         e.trace = {8'd1, 8'd8, 8'd8, 8'd8, 8'd1}; e.nbusy = 19;
      end
      return e;
   endfunction

   // Present one start pulse; optionally register the expected response
   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r, input bit push);
      @(negedge clk);
      dividend_in = a; divisor_in = b; start = 1'b1;
      if (push) sb.push_back(mk(q, r, b, cyc + 1 + ((b == 0) ? 0 : 19)));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 64'(sb.size()), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", {quotient, remainder, done, busy, div_by_zero},
          19'h0);
      chk("reset_strobes_latches",
          {load, shift_en, add_en, sub_en, final_add, count_en, dividend_q, divisor_q},
          22'h0);
      reset = 1'b0;

      issue(8'd20,  8'd3, 8'd6,   8'd2, 1'b1); drain();
      issue(8'd201, 8'd5, 8'd40,  8'd1, 1'b1); drain();
      issue(8'd5,   8'd7, 8'd0,   8'd5, 1'b1); drain();
      issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b1); drain();
      issue(8'd7,   8'd0, 8'hFF,  8'd7, 1'b1); drain();

      // 100/9 with an ignored start mid-operation, then 50/4 back-to-back
      issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b1);
      repeat (3) @(negedge clk);
      dividend_in = 8'd50; divisor_in = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int t = 0;
         while (!done && t < 40) begin
            @(negedge clk);
            t++;
         end
         if (!done) chk("first_done_timeout", 0, 1);
      end
      dividend_in = 8'd50; divisor_in = 8'd4; start = 1'b1;
      sb.push_back(mk(8'd12, 8'd2, 8'd4, cyc + 1 + 19));
      @(negedge clk);
      start = 1'b0;
      drain();

      // Asynchronous reset in the middle of 20/3: no result may appear
      issue(8'd20, 8'd3, 8'd0, 8'd0, 1'b0);
      repeat (8) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midreset_busy_done", {busy, done}, 2'b00);
      chk("midreset_strobes",
          {load, shift_en, add_en, sub_en, final_add, count_en}, 6'h0);
      chk("midreset_results", {quotient, remainder, div_by_zero}, 17'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      issue(8'd20, 8'd3, 8'd6, 8'd2, 1'b1); drain();

      chk("strobe_overlap_cycles", 64'(ovl), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
